// File: rtl/posit_defines.sv
// Shared posit definitions for the multiplier stream wrapper: word width and
// the product record buffered in the result FIFO.
package posit_defines;

  localparam int POSIT_NBITS = 32;

  typedef struct packed {
    logic [POSIT_NBITS-1:0] result;
    logic                   inf;
    logic                   zero;
  } mult_entry_t;

endpackage

// File: rtl/posit_result_fifo.sv
// Show-ahead in-order FIFO for multiplier products. Push and pop may coincide
// in any state, including full; a synchronous clear empties it.
module posit_result_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a push only lands if the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/posit_mult_stream.sv
// Valid/ready wrapper around the fixed-latency posit multiplier with tag pipe,
// in-order result FIFO and credit back-pressure. Optional: POSIT_MULT_STREAM_STATS_EN.
module posit_mult_stream
  import posit_defines::*;
#(
  parameter int NBITS      = POSIT_NBITS,
  parameter int TAG_W      = 8,
  parameter int MULT_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [NBITS-1:0] mult_in1,
  output logic [NBITS-1:0] mult_in2,
  output logic             mult_start,
  input  logic [NBITS-1:0] mult_result,
  input  logic             mult_inf,
  input  logic             mult_zero,
  input  logic             mult_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_result,
  output logic             out_inf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             overflow_err
`ifdef POSIT_MULT_STREAM_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_inf,
  output logic [31:0]      stat_zero,
  output logic [31:0]      stat_stall
`endif
);

  localparam int EW  = NBITS + 2 + TAG_W;
  localparam int LW  = $clog2(MULT_LAT + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(MULT_LAT + FIFO_DEPTH + 1);

  generate
    if (FIFO_DEPTH < MULT_LAT + 2) begin : g_depth_chk
      $error("FIFO_DEPTH must be at least MULT_LAT+2");
    end
    if (NBITS != POSIT_NBITS) begin : g_width_chk
      $error("NBITS must match posit_defines::POSIT_NBITS");
    end
  endgenerate

  logic             fire;
  logic             pop;
  logic             tail_vld;
  logic [TAG_W-1:0] tail_tag;
  logic             fifo_empty;
  logic             fifo_full;
  logic [FCW-1:0]   fifo_cnt;
  logic [LW-1:0]    inflight_cnt;
  logic [LW-1:0]    mask_cnt;
  logic [OW-1:0]    occ;
  logic             done_mismatch;
  logic             fifo_overrun;
  logic             vld_p [MULT_LAT];
  logic [TAG_W-1:0] tag_p [MULT_LAT];
  mult_entry_t      wr_entry;
  mult_entry_t      head_entry;
  logic [EW-1:0]    head_word;
  logic [TAG_W-1:0] head_tag;

  // Credits count everything already committed: in the multiplier or in the FIFO.
  assign occ        = OW'(inflight_cnt) + OW'(fifo_cnt);
  assign in_ready   = (occ < OW'(FIFO_DEPTH)) & ~flush & reset_n;
  assign fire       = in_valid & in_ready;
  assign mult_start = fire;
  assign mult_in1   = fire ? in_a : '0;
  assign mult_in2   = fire ? in_b : '0;

  // Stage boundary: issue -> tag/valid pipe, tail aligned with the multiplier output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MULT_LAT; i++) vld_p[i] <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < MULT_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= fire;
      for (int i = 1; i < MULT_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < MULT_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  assign tail_vld = vld_p[MULT_LAT-1];
  assign tail_tag = tag_p[MULT_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_cnt <= '0;
    end else if (flush) begin
      inflight_cnt <= '0;
    end else begin
      case ({fire, tail_vld})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Done pulses from work issued before a flush or reset still drain out of
  // the multiplier; the consistency check stays blind until they are gone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_cnt <= LW'(MULT_LAT);
    end else if (flush) begin
      mask_cnt <= LW'(MULT_LAT);
    end else if (mask_cnt != '0) begin
      mask_cnt <= mask_cnt - 1'b1;
    end
  end

  assign done_mismatch = (mask_cnt == '0) & ~flush & (tail_vld != mult_done);
  assign fifo_overrun  = tail_vld & fifo_full & ~pop & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err <= 1'b0;
    end else if (done_mismatch | fifo_overrun) begin
      overflow_err <= 1'b1;
    end
  end

  // Stage boundary: multiplier output -> result FIFO
  always_comb begin
    wr_entry        = '0;
    wr_entry.result = mult_result;
    wr_entry.inf    = mult_inf;
    wr_entry.zero   = mult_zero;
  end

  posit_result_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (flush),
    .push     (tail_vld),
    .push_data({wr_entry, tail_tag}),
    .pop      (pop),
    .head     (head_word),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_cnt)
  );

  assign head_entry = head_word[EW-1:TAG_W];
  assign head_tag   = head_word[TAG_W-1:0];

  // Outputs are forced to zero while empty so stale storage never shows.
  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign out_result = out_valid ? head_entry.result : '0;
  assign out_inf    = out_valid & head_entry.inf;
  assign out_zero   = out_valid & head_entry.zero;
  assign out_tag    = out_valid ? head_tag : '0;

`ifdef POSIT_MULT_STREAM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued <= '0;
      stat_inf    <= '0;
      stat_zero   <= '0;
      stat_stall  <= '0;
    end else begin
      if (fire)                  stat_issued <= stat_issued + 1'b1;
      if (pop & out_inf)         stat_inf    <= stat_inf + 1'b1;
      if (pop & out_zero)        stat_zero   <= stat_zero + 1'b1;
      if (in_valid & ~in_ready)  stat_stall  <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_mult_stream.sv
// Self-checking bench for posit_mult_stream with a behavioural 4-cycle stand-in
// multiplier and a queue-based in-order product model.
`timescale 1ns/1ps
module tb_posit_mult_stream;

  localparam int LAT = 4;
  localparam logic [31:0] ONE = 32'h4000_0000;
  localparam logic [31:0] NAR = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] res;
    logic        inf;
    logic        zero;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [7:0]  in_tag = '0;
  logic [31:0] mult_in1;
  logic [31:0] mult_in2;
  logic        mult_start;
  logic [31:0] mult_result;
  logic        mult_inf;
  logic        mult_zero;
  logic        mult_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_inf;
  logic        out_zero;
  logic [7:0]  out_tag;
  logic        overflow_err;
`ifdef POSIT_MULT_STREAM_STATS_EN
  logic [31:0] stat_issued, stat_inf, stat_zero, stat_stall;
`endif

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t model_q[$];

  always #5 clk = ~clk;

  posit_mult_stream dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_start(mult_start),
    .mult_result(mult_result), .mult_inf(mult_inf), .mult_zero(mult_zero), .mult_done(mult_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_inf(out_inf), .out_zero(out_zero), .out_tag(out_tag),
    .overflow_err(overflow_err)
`ifdef POSIT_MULT_STREAM_STATS_EN
    , .stat_issued(stat_issued), .stat_inf(stat_inf), .stat_zero(stat_zero), .stat_stall(stat_stall)
`endif
  );

  // Stand-in product: exact for 1.0 operands, otherwise an order-sensitive scramble.
  function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] b);
    if (a == ONE) return b;
    if (b == ONE) return a;
    return (a ^ {b[28:0], b[31:29]}) + 32'h0000_9E37;
  endfunction

  function automatic exp_t ref_mult(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
    exp_t e;
    e = '0;
    e.tag = tag;
    if (a == NAR || b == NAR) begin
      e.res = NAR; e.inf = 1'b1;
    end else if (a == 0 || b == 0) begin
      e.res = '0; e.zero = 1'b1;
    end else begin
      e.res = mix(a, b);
    end
    return e;
  endfunction

  logic pm_vld [LAT] = '{default: 1'b0};
  exp_t pm_data [LAT] = '{default: '0};

  always @(posedge clk) begin
    pm_vld[0]  <= mult_start;
    pm_data[0] <= ref_mult(mult_in1, mult_in2, 8'h00);
    for (int i = 1; i < LAT; i++) begin
      pm_vld[i]  <= pm_vld[i-1];
      pm_data[i] <= pm_data[i-1];
    end
  end

  assign mult_done   = pm_vld[LAT-1];
  assign mult_result = pm_data[LAT-1].res;
  assign mult_inf    = pm_data[LAT-1].inf;
  assign mult_zero   = pm_data[LAT-1].zero;

  // One clock: drive at the falling edge, observe 1ns later, record accepted operands.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [7:0] tag, input logic ordy, input logic fl,
                      output logic fired, output logic popped, output exp_t obs);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_tag = tag; out_ready = ordy; flush = fl;
    #1;
    fired  = in_valid & in_ready;
    popped = out_valid & out_ready;
    obs    = '{res: out_result, inf: out_inf, zero: out_zero, tag: out_tag};
    if (fl) model_q.delete();
    else if (fired) model_q.push_back(ref_mult(a, b, tag));
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_a = ONE; in_b = ONE; out_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({in_ready, mult_start, mult_in1, mult_in2} !== '0) begin
      tests_failed++;
      $display("FAIL reset_issue: got rdy=%b start=%b in1=%h in2=%h, expected all 0", in_ready, mult_start, mult_in1, mult_in2);
    end
    tests_run++;
    if ({out_valid, out_result, out_inf, out_zero, out_tag, overflow_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got vld=%b res=%h inf=%b zero=%b tag=%h err=%b, expected all 0",
               out_valid, out_result, out_inf, out_zero, out_tag, overflow_err);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    model_q.delete();
  endtask

  task automatic test_single_op(input string nm);
    logic f, p;
    exp_t o;
    int lat;
    step(1'b1, ONE, ONE, 8'h11, 1'b1, 1'b0, f, p, o);
    tests_run++;
    if (f !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_fire: got %b expected 1", nm, f);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0, f, p, o);
      if (i == 1) begin
        tests_run++;
        if ({mult_start, mult_in1, mult_in2} !== '0) begin
          tests_failed++;
          $display("FAIL %s_idle_mult: got start=%b in1=%h in2=%h expected 0", nm, mult_start, mult_in1, mult_in2);
        end
      end
      if (p) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if (lat != 5) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d expected 5", nm, lat);
    end
    tests_run++;
    if ({o.res, o.inf, o.zero, o.tag} !== {ONE, 1'b0, 1'b0, 8'h11}) begin
      tests_failed++;
      $display("FAIL %s_product: got res=%h inf=%b zero=%b tag=%h expected res=40000000 tag=11",
               nm, o.res, o.inf, o.zero, o.tag);
    end
    if (p && model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic test_back_to_back();
    logic f, p;
    exp_t o, e;
    int n_out, gaps, not_ready;
    bit started;
    n_out = 0; gaps = 0; not_ready = 0; started = 0;
    for (int i = 0; i < 130; i++) begin
      if (i < 100) begin
        step(1'b1, $urandom, $urandom, i[7:0], 1'b1, 1'b0, f, p, o);
        if (!f) not_ready++;
      end else begin
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, f, p, o);
      end
      if (p) begin
        started = 1;
        n_out++;
        e = (model_q.size() > 0) ? model_q.pop_front() : '0;
        tests_run++;
        if (o !== e) begin
          tests_failed++;
          $display("FAIL stream_item: got res=%h inf=%b zero=%b tag=%h expected res=%h inf=%b zero=%b tag=%h",
                   o.res, o.inf, o.zero, o.tag, e.res, e.inf, e.zero, e.tag);
        end
      end else if (started && n_out < 100) begin
        gaps++;
      end
    end
    tests_run++;
    if (not_ready != 0) begin
      tests_failed++;
      $display("FAIL stream_in_ready: got %0d stalled cycles expected 0", not_ready);
    end
    tests_run++;
    if (n_out != 100 || gaps != 0) begin
      tests_failed++;
      $display("FAIL stream_rate: got %0d products with %0d gaps expected 100 with 0", n_out, gaps);
    end
  endtask

  task automatic test_back_pressure();
    logic f, p;
    exp_t o, e;
    int fires, n;
    fires = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, $urandom, 8'(8'h80 + i), 1'b0, 1'b0, f, p, o);
      if (f) fires++;
    end
    tests_run++;
    if (fires != 8 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_fill: got fires=%0d rdy=%b vld=%b expected fires=8 rdy=0 vld=1", fires, in_ready, out_valid);
    end
    step(1'b1, $urandom, $urandom, 8'hC0, 1'b1, 1'b0, f, p, o);
    tests_run++;
    if (f !== 1'b0 || p !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_pop_cycle: got fire=%b pop=%b expected fire=0 pop=1", f, p);
    end
    e = (model_q.size() > 0) ? model_q.pop_front() : '0;
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL bp_pop_data: got res=%h tag=%h expected res=%h tag=%h", o.res, o.tag, e.res, e.tag);
    end
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, $urandom, 8'(8'hD0 + i), 1'b0, 1'b0, f, p, o);
      if (f) fires++;
    end
    tests_run++;
    if (fires != 1) begin
      tests_failed++;
      $display("FAIL bp_refill: got %0d fires expected 1", fires);
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0, f, p, o);
      if (p) begin
        n++;
        e = (model_q.size() > 0) ? model_q.pop_front() : '0;
        tests_run++;
        if (o !== e) begin
          tests_failed++;
          $display("FAIL bp_drain_item: got res=%h tag=%h expected res=%h tag=%h", o.res, o.tag, e.res, e.tag);
        end
      end
    end
    tests_run++;
    if (n != 8) begin
      tests_failed++;
      $display("FAIL bp_drain_count: got %0d expected 8", n);
    end
  endtask

  task automatic test_special_values();
    logic f, p;
    exp_t o, e;
    logic [31:0] r;
    logic [31:0] opa [6];
    logic [31:0] opb [6];
    int n;
    r = ($urandom | 32'h1) & 32'h7FFF_FFFF;
    opa = '{32'h0, r, NAR, r, NAR, 32'h0};
    opb = '{r, 32'h0, r, NAR, 32'h0, 32'h0};
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 6) step(1'b1, opa[i], opb[i], 8'(8'h50 + i), 1'b1, 1'b0, f, p, o);
      else       step(1'b0, '0, '0, '0, 1'b1, 1'b0, f, p, o);
      if (p) begin
        n++;
        e = (model_q.size() > 0) ? model_q.pop_front() : '0;
        tests_run++;
        if (o !== e) begin
          tests_failed++;
          $display("FAIL special_item: got res=%h inf=%b zero=%b tag=%h expected res=%h inf=%b zero=%b tag=%h",
                   o.res, o.inf, o.zero, o.tag, e.res, e.inf, e.zero, e.tag);
        end
      end
    end
    tests_run++;
    if (n != 6) begin
      tests_failed++;
      $display("FAIL special_count: got %0d expected 6", n);
    end
  endtask

  task automatic test_flush();
    logic f, p;
    exp_t o;
    int fires, stale;
    fires = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, $urandom, $urandom, 8'(8'hA0 + i), 1'b0, 1'b0, f, p, o);
      if (f) fires++;
    end
    repeat (6) step(1'b0, '0, '0, '0, 1'b0, 1'b0, f, p, o);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, $urandom, 8'(8'hB0 + i), 1'b0, 1'b0, f, p, o);
      if (f) fires++;
    end
    step(1'b1, $urandom, $urandom, 8'hBF, 1'b0, 1'b1, f, p, o);
    tests_run++;
    if (fires != 5 || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_setup: got fires=%0d flush_cycle_fire=%b expected 5 and 0", fires, f);
    end
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, f, p, o);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_after: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
    end
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0, f, p, o);
      if (out_valid) stale++;
    end
    tests_run++;
    if (stale != 0 || overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stale: got %0d stale cycles err=%b expected 0 and 0", stale, overflow_err);
    end
  endtask

  task automatic test_reset_midstream();
    logic f, p;
    exp_t o;
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, $urandom, 8'(8'hE0 + i), 1'b1, 1'b0, f, p, o);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, mult_start, out_valid, out_result, out_inf, out_zero, out_tag, overflow_err} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got rdy=%b start=%b vld=%b res=%h inf=%b zero=%b tag=%h err=%b expected all 0",
               in_ready, mult_start, out_valid, out_result, out_inf, out_zero, out_tag, overflow_err);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    model_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    test_single_op("post_reset");
    repeat (6) step(1'b0, '0, '0, '0, 1'b1, 1'b0, f, p, o);
    tests_run++;
    if (overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_err: got %b expected 0", overflow_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_op("single");
    test_back_to_back();
    test_back_pressure();
    test_special_values();
    test_flush();
    test_reset_midstream();
    tests_run++;
    if (model_q.size() != 0 || overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL final_state: got %0d unmatched products err=%b expected 0 and 0", model_q.size(), overflow_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
